button_debounce_multi: RTL and testbench
========================================

// Module: button_debounce_multi
// PURPOSE
//  Parametrised N-channel button debouncer for the clock's set inputs (fast_set, set_hours, set_minutes, ...).
//  Synchronises raw button pins and qualifies them on the shared ~4 kHz i_debounce_stb from clk_gen.
//  Emits a debounced level plus one-cycle press/release/auto-repeat strobes for the time-set logic.
//  Adds symmetric release filtering and hold-to-repeat.
// PARAMETERS
//  NUM_CH        3  number of independent button channels (1..16)
//  NUM_SAMPLES   5  consecutive disagreeing strobe samples required to flip a level (2..15)
//  SYMMETRIC     1  1: release is also filtered by NUM_SAMPLES; 0: release on first 0 sample (legacy)
//  HOLD_TICKS  2000 strobes of continuous press before first repeat strobe (0 disables repeat)
//  REPEAT_TICKS 400 strobes between subsequent repeat strobes while held (>=1)
// PORTS
//  i_clk           in   1       system clock
//  i_reset         in   1       asynchronous, active-high reset
//  i_debounce_stb  in   1       one-i_clk sample strobe (~4 kHz)
//  i_buttons       in   NUM_CH  raw asynchronous button inputs, 1 = pressed
//  o_db            out  NUM_CH  debounced level per channel
//  o_press_stb     out  NUM_CH  1-cycle pulse on debounced 0->1
//  o_release_stb   out  NUM_CH  1-cycle pulse on debounced 1->0
//  o_repeat_stb    out  NUM_CH  1-cycle pulse per auto-repeat interval while held
// BEHAVIOUR
//  - Reset (async assert, sync release on i_clk): all outputs 0, all sync FFs, sample counters and hold counters 0.
//  - Sync: 2-FF synchroniser per channel on i_clk, every cycle; sampling uses the 2nd stage only.
//  - Samples are taken only in cycles with i_debounce_stb=1; no state changes otherwise, except: sync FFs always update; strobes clear.
//  - Per channel, on strobe: sample==o_db -> cnt<=0.
//    sample!=o_db and cnt<NUM_SAMPLES-1 -> cnt<=cnt+1.
//    sample!=o_db and cnt==NUM_SAMPLES-1 -> o_db<=sample, cnt<=0.
//  - SYMMETRIC=0: strobe sample 0 while o_db=1 -> o_db<=0 immediately, cnt<=0.
//  - Latency: o_db flips on the i_clk edge of the NUM_SAMPLES-th consecutive disagreeing strobe; the input reaches the sampled stage 2 clk after the pin.
//  - o_press_stb/o_release_stb: registered, asserted the same edge o_db changes, exactly 1 i_clk wide.
//  - Any agreeing sample mid-count restarts the count (bounce rejection); cnt never exceeds NUM_SAMPLES-1.
//  - Hold counter hcnt (width clog2(max(HOLD_TICKS,REPEAT_TICKS))+1):
//    - cleared when o_db=0 and on press edge.
//    - +1 per strobe while o_db=1.
//    - hcnt==HOLD_TICKS-1 on strobe -> o_repeat_stb pulse, hcnt<=HOLD_TICKS-REPEAT_TICKS (next pulse after REPEAT_TICKS strobes).
//    - Wraps this way indefinitely, never overflows.
//  - No repeat pulse in the same cycle as o_press_stb; release mid-interval clears hcnt, no pulse.
//  - HOLD_TICKS=0: o_repeat_stb tied 0, hold logic not generated.
//  - Channels fully independent; simultaneous events on several channels each produce their own pulses same cycle.
//  - Reset mid-count/mid-hold: immediate return to reset state, no strobe emitted on reset or its release.
//  - i_debounce_stb held high for k cycles counts as k samples (caller must supply 1-cycle strobes).
// STRUCTURE
//  - Shared package/include: none needed. Width helper clog2 goes in the common clock header, reused by clk_gen.
//  - Sub-module debounce_channel: one channel's sync, sample counter, hold counter and strobes, same parameters minus NUM_CH.
//    Top = generate loop over NUM_CH instances.
// TESTING  (NUM_CH=3, NUM_SAMPLES=5, SYMMETRIC=1, HOLD_TICKS=8, REPEAT_TICKS=4; strobe every 20 clk)
//  1. Reset: i_reset=1 with i_buttons=3'b111 -> all outputs 0. Release reset, hold pins -> o_db=3'b111 after the 5th strobe, o_press_stb=3'b111 for 1 clk.
//  2. Bounce: ch0 toggles every 7 clk for 300 clk, then steady 1.
//     -> no o_db[0] change during bounce; rises on 5th strobe after settling; exactly one press pulse.
//  3. Release filter: ch1 held then 0 for 4 strobes, 1 again -> o_db[1] stays 1. 0 for 5 strobes -> falls, one o_release_stb[1].
//  4. Repeat: ch2 held 20 strobes after press -> o_repeat_stb[2] at strobes 8,12,16,20 after press (4 pulses).
//     Release at strobe 18 -> only 3 pulses, hcnt=0.
//  5. Simultaneous: all 3 pins 0->1 same clk -> o_press_stb=3'b111 same cycle; ch0/ch1 SYMMETRIC=0 build: one 0 sample drops o_db.
//  6. Mid-op reset: assert i_reset at strobe 3 of a press count and at hold strobe 6 -> outputs 0 at once, no pulses; fresh count after release.

Source files
------------

// File: rtl/button_debounce_multi_pkg.sv
// ============================================================================
//  Module      : button_debounce_multi_pkg
//  Description : Shared widths and constant helpers for the button debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_debounce_multi_pkg;

    // Sample counter must hold NUM_SAMPLES-1, and NUM_SAMPLES tops out at 15
    localparam int c_CNT_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce_multi_channel.sv
// ============================================================================
//  Module      : button_debounce_multi_channel
//  Description : One button channel: synchroniser, strobe-qualified sample
//                filter, press/release strobes and hold-to-repeat timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce_multi_channel
    import button_debounce_multi_pkg::*;
#(
    parameter int NUM_SAMPLES  = 5,
    parameter int SYMMETRIC    = 1,
    parameter int HOLD_TICKS   = 2000,
    parameter int REPEAT_TICKS = 400
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_debounce_stb,
    input  logic i_button,
    output logic o_db,
    output logic o_press_stb,
    output logic o_release_stb,
    output logic o_repeat_stb
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NUM_SAMPLES - 1);

    logic               sync1_q, sync2_q;
    logic               db_q, db_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;

    always_comb begin
        db_d      = db_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (i_debounce_stb) begin
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if ((SYMMETRIC == 0) && db_q) begin
                // Legacy mode: the first low sample releases immediately
                db_d      = 1'b0;
                cnt_d     = '0;
                release_d = 1'b1;
            end else if (cnt_q == c_CNT_LAST) begin
                db_d      = sync2_q;
                cnt_d     = '0;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_button;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_db          = db_q;
    assign o_press_stb   = press_q;
    assign o_release_stb = release_q;

    generate
        if (HOLD_TICKS > 0) begin : g_hold
            localparam int HW = clog2(max_int(HOLD_TICKS, REPEAT_TICKS)) + 1;
            localparam logic [HW-1:0] c_HOLD_LAST   = HW'(HOLD_TICKS - 1);
            localparam logic [HW-1:0] c_HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

            logic [HW-1:0] hcnt_q, hcnt_d;
            logic          repeat_q, repeat_d;

            always_comb begin
                hcnt_d   = hcnt_q;
                repeat_d = 1'b0;
                // Not held, or releasing on this strobe: restart without a pulse
                if (!db_q || !db_d) begin
                    hcnt_d = '0;
                end else if (i_debounce_stb) begin
                    if (hcnt_q == c_HOLD_LAST) begin
                        repeat_d = 1'b1;
                        hcnt_d   = c_HOLD_RELOAD;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    hcnt_q   <= '0;
                    repeat_q <= 1'b0;
                end else begin
                    hcnt_q   <= hcnt_d;
                    repeat_q <= repeat_d;
                end
            end

            assign o_repeat_stb = repeat_q;
        end else begin : g_no_hold
            assign o_repeat_stb = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/button_debounce_multi.sv
// ============================================================================
//  Module      : button_debounce_multi
//  Description : N-channel button debouncer with press/release/repeat strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce_multi
    import button_debounce_multi_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int NUM_SAMPLES  = 5,
    parameter int SYMMETRIC    = 1,
    parameter int HOLD_TICKS   = 2000,
    parameter int REPEAT_TICKS = 400
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_debounce_stb,
    input  logic [NUM_CH-1:0] i_buttons,
    output logic [NUM_CH-1:0] o_db,
    output logic [NUM_CH-1:0] o_press_stb,
    output logic [NUM_CH-1:0] o_release_stb,
    output logic [NUM_CH-1:0] o_repeat_stb
);

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            button_debounce_multi_channel #(
                .NUM_SAMPLES  (NUM_SAMPLES),
                .SYMMETRIC    (SYMMETRIC),
                .HOLD_TICKS   (HOLD_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS)
            ) u_channel (
                .i_clk          (i_clk),
                .i_reset        (i_reset),
                .i_debounce_stb (i_debounce_stb),
                .i_button       (i_buttons[g]),
                .o_db           (o_db[g]),
                .o_press_stb    (o_press_stb[g]),
                .o_release_stb  (o_release_stb[g]),
                .o_repeat_stb   (o_repeat_stb[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_multi.sv
// ============================================================================
//  Module      : tb_button_debounce_multi
//  Description : Scoreboarded bench for button_debounce_multi (plus a legacy
//                non-symmetric instance checked directly).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb;
    logic [2:0] buttons;
    logic [2:0] db, press, rel, rep;
    logic [2:0] l_db, l_press, l_rel, l_rep;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_idx = 0;

    typedef struct {
        int         idx;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] rp;
        logic [2:0] d;
    } ev_t;

    ev_t q[$];
    ev_t e;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .NUM_CH(3), .NUM_SAMPLES(5), .SYMMETRIC(1), .HOLD_TICKS(8), .REPEAT_TICKS(4)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_debounce_stb(stb), .i_buttons(buttons),
        .o_db(db), .o_press_stb(press), .o_release_stb(rel), .o_repeat_stb(rep)
    );

    button_debounce_multi #(
        .NUM_CH(3), .NUM_SAMPLES(5), .SYMMETRIC(0), .HOLD_TICKS(0), .REPEAT_TICKS(4)
    ) dut_legacy (
        .i_clk(clk), .i_reset(rst), .i_debounce_stb(stb), .i_buttons(buttons),
        .o_db(l_db), .o_press_stb(l_press), .o_release_stb(l_rel), .o_repeat_stb(l_rep)
    );

    // One-cycle strobe every 20 clocks, changed on the falling edge
    initial begin
        stb = 1'b0;
        forever begin
            repeat (19) @(negedge clk);
            stb = 1'b1;
            @(negedge clk);
            stb = 1'b0;
        end
    end

    always @(posedge clk) if (stb) stb_idx <= stb_idx + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic wait_stb(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!stb) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic expect_ev(input int idx, input logic [2:0] p, input logic [2:0] r,
                             input logic [2:0] rp, input logic [2:0] d);
        ev_t x;
        x.idx = idx; x.p = p; x.r = r; x.rp = rp; x.d = d;
        q.push_back(x);
    endtask

    // Monitor: every cycle with any strobe active must match the next expected event
    always @(negedge clk) begin
        if ((press | rel | rep) != 3'b000) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: strobe %0d press=%b rel=%b rep=%b db=%b, expected no pulse",
                         stb_idx, press, rel, rep, db);
            end else begin
                e = q.pop_front();
                if (stb_idx != e.idx || press !== e.p || rel !== e.r || rep !== e.rp || db !== e.d) begin
                    n_fail++;
                    $display("FAIL event: got strobe=%0d press=%b rel=%b rep=%b db=%b, expected strobe=%0d press=%b rel=%b rep=%b db=%b",
                             stb_idx, press, rel, rep, db, e.idx, e.p, e.r, e.rp, e.d);
                end
            end
        end
    end

    initial begin
        int s;
        int p;
        rst     = 1'b1;
        buttons = 3'b111;

        // 1. Reset state, then held pins debounce after the 5th strobe
        repeat (5) @(negedge clk);
        check3("reset_db", db, 3'b000);
        check3("reset_press", press, 3'b000);
        check3("reset_release", rel, 3'b000);
        check3("reset_repeat", rep, 3'b000);
        wait_stb(1);
        s = stb_idx;
        rst = 1'b0;
        expect_ev(s + 5, 3'b111, 3'b000, 3'b000, 3'b111);
        wait_stb(5);
        check3("t1_db_high", db, 3'b111);
        buttons = 3'b000;
        s = stb_idx;
        expect_ev(s + 5, 3'b000, 3'b111, 3'b000, 3'b000);
        wait_stb(5);
        check3("t1_db_low", db, 3'b000);

        // 2. Bounce rejection on ch0
        buttons[0] = 1'b1;
        for (int i = 0; i < 43; i++) begin
            repeat (7) @(negedge clk);
            buttons[0] = ~buttons[0];
        end
        buttons[0] = 1'b0;
        wait_stb(2);
        check3("t2_db_after_bounce", db, 3'b000);
        s = stb_idx;
        buttons[0] = 1'b1;
        expect_ev(s + 5, 3'b001, 3'b000, 3'b000, 3'b001);
        expect_ev(s + 10, 3'b000, 3'b001, 3'b000, 3'b000);
        wait_stb(5);
        buttons[0] = 1'b0;
        wait_stb(5);

        // 3. Release filter on ch1: 4 low samples ignored, 5 release
        s = stb_idx;
        p = s + 5;
        buttons = 3'b010;
        expect_ev(p, 3'b010, 3'b000, 3'b000, 3'b010);
        expect_ev(p + 8, 3'b000, 3'b000, 3'b010, 3'b010);
        expect_ev(p + 10, 3'b000, 3'b010, 3'b000, 3'b000);
        wait_stb(5);
        buttons = 3'b000;
        wait_stb(4);
        buttons = 3'b010;
        wait_stb(1);
        check3("t3_db_held", db, 3'b010);
        buttons = 3'b000;
        wait_stb(5);

        // 4. Hold-to-repeat on ch2, release at strobe 18, then a fresh hold
        s = stb_idx;
        p = s + 5;
        buttons = 3'b100;
        expect_ev(p, 3'b100, 3'b000, 3'b000, 3'b100);
        expect_ev(p + 8, 3'b000, 3'b000, 3'b100, 3'b100);
        expect_ev(p + 12, 3'b000, 3'b000, 3'b100, 3'b100);
        expect_ev(p + 16, 3'b000, 3'b000, 3'b100, 3'b100);
        expect_ev(p + 18, 3'b000, 3'b100, 3'b000, 3'b000);
        wait_stb(5);
        wait_stb(13);
        buttons = 3'b000;
        wait_stb(5);
        s = stb_idx;
        p = s + 5;
        buttons = 3'b100;
        expect_ev(p, 3'b100, 3'b000, 3'b000, 3'b100);
        expect_ev(p + 8, 3'b000, 3'b000, 3'b100, 3'b100);
        expect_ev(p + 10, 3'b000, 3'b100, 3'b000, 3'b000);
        wait_stb(5);
        wait_stb(5);
        buttons = 3'b000;
        wait_stb(5);

        // 5. Simultaneous press; legacy build drops on one low sample
        s = stb_idx;
        p = s + 5;
        buttons = 3'b111;
        expect_ev(p, 3'b111, 3'b000, 3'b000, 3'b111);
        expect_ev(p + 5, 3'b000, 3'b001, 3'b000, 3'b110);
        expect_ev(p + 6, 3'b000, 3'b110, 3'b000, 3'b000);
        wait_stb(5);
        check3("t5_legacy_db_rise", l_db, 3'b111);
        buttons = 3'b110;
        wait_stb(1);
        check3("t5_legacy_db_drop", l_db, 3'b110);
        check3("t5_main_db_kept", db, 3'b111);
        buttons = 3'b000;
        wait_stb(5);
        check3("t5_legacy_db_low", l_db, 3'b000);
        check3("t5_legacy_repeat", l_rep, 3'b000);

        // 6. Reset mid-count and mid-hold
        s = stb_idx;
        buttons = 3'b001;
        wait_stb(3);
        rst = 1'b1;
        #1;
        check3("t6_db_count_reset", db, 3'b000);
        wait_stb(1);
        rst = 1'b0;
        p = stb_idx + 5;
        expect_ev(p, 3'b001, 3'b000, 3'b000, 3'b001);
        wait_stb(5);
        wait_stb(6);
        rst = 1'b1;
        #1;
        check3("t6_db_hold_reset", db, 3'b000);
        check3("t6_press_hold_reset", press, 3'b000);
        buttons = 3'b000;
        wait_stb(1);
        rst = 1'b0;
        wait_stb(6);
        check3("t6_db_after_release", db, 3'b000);

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expected events never seen, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
